// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch front end: default widths,
// reset vector, prefetch depth and the fetch FSM state type.
package fetch_unit_pkg;

    localparam int          FETCH_DATA_WIDTH = 32;
    localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
    localparam int          FETCH_DEPTH      = 2;
    localparam int          FETCH_CNT_W      = $clog2(FETCH_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Two-entry {pc, instruction} buffer between the memory response path and the
// decoder. Flush has priority over push/pop; the head reads as zero when empty.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [FETCH_CNT_W-1:0] count
);

    logic [WIDTH-1:0]       r_mem [FETCH_DEPTH];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [FETCH_CNT_W-1:0] r_count;
    logic                   w_pop;
    logic                   w_push;

    assign w_pop  = pop && (r_count != '0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_push = push && ((r_count != FETCH_CNT_W'(FETCH_DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + FETCH_CNT_W'(w_push) - FETCH_CNT_W'(w_pop);
        end
    end

    assign empty     = (r_count == '0);
    assign full      = (r_count == FETCH_CNT_W'(FETCH_DEPTH));
    assign count     = r_count;
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited prefetch into a 2-entry buffer, with
// redirect handling that discards responses to requests already in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] instr_pc
);

    fetch_state_t           r_state;
    logic [DATA_WIDTH-1:0]  r_fetch_pc;
    logic [DATA_WIDTH-1:0]  r_resp_pc;
    logic [1:0]             r_outstanding;
    logic [1:0]             r_discard;

    logic                   w_active;
    logic                   w_req_fire;
    logic                   w_resp_live;
    logic                   w_redirect;
    logic                   w_push;
    logic                   w_pop;
    logic [1:0]             w_out_next;
    logic [2:0]             w_credit_used;
    logic [DATA_WIDTH-1:0]  w_target;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [FETCH_CNT_W-1:0] w_fifo_count;
    logic [2*DATA_WIDTH-1:0] w_head;
    logic                   w_unused;

    assign w_unused      = &{1'b0, redirect_pc[1:0]};
    assign w_active      = (r_state != ST_IDLE);
    assign w_credit_used = 3'(r_outstanding) + 3'(w_fifo_count);
    assign imem_req_valid = w_active && !w_fifo_full && (w_credit_used < 3'(FETCH_DEPTH));
    assign imem_addr     = r_fetch_pc;

    assign w_req_fire  = imem_req_valid && imem_req_ready;
    // Responses with nothing in flight are strays (e.g. from before a reset).
    assign w_resp_live = imem_resp_valid && (r_outstanding != 2'd0);
    assign w_redirect  = redirect_valid && w_active;
    assign w_push      = w_resp_live && !w_redirect && (r_discard == 2'd0);
    assign w_pop       = instr_valid && instr_ready;
    assign w_out_next  = r_outstanding + 2'(w_req_fire) - 2'(w_resp_live);
    assign w_target    = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
        end else begin
            r_outstanding <= w_out_next;
            case (r_state)
                ST_IDLE: r_state <= ST_RUN;
                default: begin
                    if (w_redirect) begin
                        // Everything still in flight (incl. this cycle's request) is stale.
                        r_fetch_pc <= w_target;
                        r_resp_pc  <= w_target;
                        r_discard  <= w_out_next;
                        r_state    <= (w_out_next != 2'd0) ? ST_FLUSH : ST_RUN;
                    end else begin
                        if (w_req_fire) begin
                            r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
                        end
                        if (w_resp_live) begin
                            if (r_discard != 2'd0) begin
                                r_discard <= r_discard - 2'd1;
                                if (r_discard == 2'd1) begin
                                    r_state <= ST_RUN;
                                end
                            end else begin
                                r_resp_pc <= r_resp_pc + DATA_WIDTH'(4);
                            end
                        end
                    end
                end
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH(2 * DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({r_resp_pc, imem_resp_data}),
        .pop       (w_pop),
        .flush     (w_redirect),
        .head_data (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign instr_valid = !w_fifo_empty;
    assign instr_pc    = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign instruction = w_head[DATA_WIDTH-1:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port imem_req_valid, output, 1, fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts request this cycle.
REQ-007 SHALL have port imem_addr, output, DATA_WIDTH, word-aligned fetch address.
REQ-008 SHALL have port imem_resp_valid, input, 1, in-order response present; never back-pressured.
REQ-009 SHALL have port imem_resp_data, input, DATA_WIDTH, fetched instruction word.
REQ-010 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-011 SHALL have port redirect_pc, input, DATA_WIDTH, redirect target; bits [1:0] ignored.
REQ-012 SHALL have port instr_valid, output, 1, instruction available to decoder.
REQ-013 SHALL have port instr_ready, input, 1, decoder consumes instruction this cycle.
REQ-014 SHALL have port instruction, output, DATA_WIDTH, word driven to decoder's instruction input.
REQ-015 SHALL have port instr_pc, output, DATA_WIDTH, address of instruction.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FLUSH; IDLE for exactly one cycle after reset release, then RUN.
REQ-017 SHALL, in RUN or FLUSH, assert imem_req_valid when outstanding + buffered < 2; imem_addr = fetch_pc.
REQ-018 SHALL, on request handshake (imem_req_valid & imem_req_ready), increment outstanding and fetch_pc by 4, wrapping modulo 2^DATA_WIDTH.
REQ-019 SHALL keep imem_addr stable while imem_req_valid is high and imem_req_ready is low.
REQ-020 SHALL write each non-discarded response with its pc into a 2-entry FIFO; instr_valid rises the cycle after the response (1-cycle latency).
REQ-021 SHALL pop the FIFO on instr_valid & instr_ready; instruction/instr_pc show the FIFO head, zero when empty.
REQ-022 SHALL, on redirect_valid, set fetch_pc = {redirect_pc[31:2],2'b00}, flush the FIFO, load discard count = outstanding (including a request accepted that cycle), and enter FLUSH if that count > 0, else stay RUN.
REQ-023 SHALL, in FLUSH, drop responses and decrement discard; return to RUN when it reaches 0; new requests may issue meanwhile.
REQ-024 SHALL drop a response arriving in the same cycle as redirect_valid.
REQ-025 SHALL complete a decoder handshake coinciding with redirect_valid, then flush; instr_valid is low the next cycle.
REQ-026 SHALL ignore imem_resp_valid when outstanding == 0 (no FIFO write).
REQ-027 SHALL never overflow the FIFO; overflow is prevented by REQ-017 credit rule.
REQ-028 SHALL support simultaneous FIFO push and pop when full or empty without loss.

Reset
REQ-029 SHALL, while rst_n low: fetch_pc = RESET_PC, state IDLE, FIFO empty, outstanding = 0, discard = 0, imem_req_valid = 0, instr_valid = 0, instruction = 0, instr_pc = 0, imem_addr = RESET_PC.
REQ-030 SHALL abandon any in-flight transaction on reset assertion mid-operation; responses after release follow REQ-026.

Structure
REQ-031 SHALL take DATA_WIDTH default, RESET_PC default, FETCH_DEPTH = 2 and the fetch_state_t enum from the shared core package.
REQ-032 SHALL instantiate one sub-module fetch_fifo (2-entry {pc, instruction} FIFO with push/pop/flush/full/empty).

Verification
REQ-033 Reset release, imem_req_ready = 1, 1-cycle memory -> requests at 0x0, 0x4, 0x8 in order; instr_valid with instr_pc 0x0 two cycles after first request accept.
REQ-034 instr_ready = 0 -> at most 2 buffered plus 0 outstanding; imem_req_valid drops; no instruction lost after instr_ready = 1.
REQ-035 Redirect to 0x103 with 2 outstanding -> next imem_addr 0x100, two responses dropped, first delivered instr_pc = 0x100.
REQ-036 imem_req_ready = 0 for 5 cycles -> imem_addr held constant, no outstanding increment.
REQ-037 Fetch near 0xFFFF_FFFC -> next address 0x0000_0000.
REQ-038 rst_n low mid-stream with 1 outstanding -> all outputs per REQ-029 asynchronously; stray response after release not delivered; fetch restarts at RESET_PC.
